// File: rtl/chaos_pkg.sv
// chaos_pkg: shared defaults, FSM state and sample type for the chaos sample reader
// Contents: default DATA_WIDTH/SYS_NUM/DEPTH, read FSM state enum, {x,y,z} sample struct.
package chaos_pkg;
  localparam int CHAOS_DATA_WIDTH = 64;
  localparam int CHAOS_SYS_NUM = 6;
  localparam int CHAOS_DEPTH = 16;
  typedef enum logic {ST_IDLE = 1'b0, ST_OUT = 1'b1} state_e;
  typedef struct packed {
    logic [CHAOS_DATA_WIDTH-1:0] x;
    logic [CHAOS_DATA_WIDTH-1:0] y;
    logic [CHAOS_DATA_WIDTH-1:0] z;
  } sample_t;
endpackage

// File: rtl/chaos_sample_ram.sv
// chaos_sample_ram: simple dual-port memory, synchronous read-first, no reset on contents
// Ports: clk; we_i/waddr_i/wdata_i write port; re_i/raddr_i read port; rdata_o registered read data
// (held until the next read enable).
module chaos_sample_ram
  import chaos_pkg::*;
#(
  parameter int W  = 3 * CHAOS_DATA_WIDTH,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [1 << AW];
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/chaos_sample_reader.sv
// chaos_sample_reader: per-system circular sample buffers with a one-at-a-time read port
// Ports: clk, rst_n (async active-low); wr_valid/wr_sys/wr_x/wr_y/wr_z sample input (no backpressure);
// rd_req_valid/rd_req_sys/rd_req_ready request handshake; rd_valid/rd_ready/rd_sys/rd_x/rd_y/rd_z
// response handshake; ovf sticky overflow; err_pulse one-cycle error.
// Build option: define CHAOS_RD_OVERWRITE_EN to overwrite the oldest sample on a full-buffer write
// instead of dropping the new one.
module chaos_sample_reader
  import chaos_pkg::*;
#(
  parameter int DATA_WIDTH = CHAOS_DATA_WIDTH,
  parameter int SYS_NUM    = CHAOS_SYS_NUM,
  parameter int DEPTH      = CHAOS_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_sys,
  input  logic [DATA_WIDTH-1:0] wr_x,
  input  logic [DATA_WIDTH-1:0] wr_y,
  input  logic [DATA_WIDTH-1:0] wr_z,
  input  logic                  rd_req_valid,
  input  logic [7:0]            rd_req_sys,
  output logic                  rd_req_ready,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [7:0]            rd_sys,
  output logic [DATA_WIDTH-1:0] rd_x,
  output logic [DATA_WIDTH-1:0] rd_y,
  output logic [DATA_WIDTH-1:0] rd_z,
  output logic                  ovf,
  output logic                  err_pulse
);
  localparam int SW = SYS_NUM > 1 ? $clog2(SYS_NUM) : 1;
  localparam int SN = 1 << SW;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [7:0] SYS_LIM = 8'(SYS_NUM);
  // State arrays are sized to the power-of-two index range so a truncated index is always legal;
  // entries at or beyond SYS_NUM are never written and stay at reset values.
  logic [PW-1:0] wr_ptr_q [SN];
  logic [PW-1:0] wr_ptr_d [SN];
  logic [PW-1:0] rd_ptr_q [SN];
  logic [PW-1:0] rd_ptr_d [SN];
  logic [CW-1:0] cnt_q [SN];
  logic [CW-1:0] cnt_d [SN];
  state_e state_q, state_d;
  logic [7:0] rd_sys_q, rd_sys_d;
  logic ovf_q, ovf_d, err_q, err_d;
  logic [SW-1:0] ws, rs;
  logic wr_in, rd_in, acc, pop, full, push, we;
  logic [3*DATA_WIDTH-1:0] rdata;
  assign ws = wr_sys[SW-1:0];
  assign rs = rd_req_sys[SW-1:0];
  assign wr_in = wr_valid && (wr_sys < SYS_LIM);
  assign rd_in = rd_req_sys < SYS_LIM;
  assign acc = (state_q == ST_IDLE) && rd_req_valid;
  // Emptiness uses the pre-cycle count, so a same-cycle write is never visible to this read.
  assign pop = acc && rd_in && (cnt_q[rs] != '0);
  assign full = cnt_q[ws] == FULL;
  // A same-system pop frees the slot the write needs; read-first RAM still returns the old sample.
  assign push = wr_in && (!full || (pop && rs == ws));
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    we = push;
    if (pop) begin
      rd_ptr_d[rs] = rd_ptr_q[rs] + 1'b1;
      cnt_d[rs] = cnt_q[rs] - 1'b1;
    end
    if (push) begin
      wr_ptr_d[ws] = wr_ptr_q[ws] + 1'b1;
      cnt_d[ws] = cnt_d[ws] + 1'b1;
    end
    if (wr_in && !push) begin
      ovf_d = 1'b1;
`ifdef CHAOS_RD_OVERWRITE_EN
      // Full buffer: wr_ptr equals rd_ptr, so writing there replaces the oldest sample.
      we = 1'b1;
      wr_ptr_d[ws] = wr_ptr_q[ws] + 1'b1;
      rd_ptr_d[ws] = rd_ptr_q[ws] + 1'b1;
`endif
    end
  end
  assign state_d = pop ? ST_OUT : (state_q == ST_OUT && rd_ready) ? ST_IDLE : state_q;
  assign rd_sys_d = pop ? rd_req_sys : rd_sys_q;
  assign err_d = (wr_valid && !wr_in) || (acc && !pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SN; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      state_q <= ST_IDLE;
      rd_sys_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      rd_sys_q <= rd_sys_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end
  chaos_sample_ram #(.W(3 * DATA_WIDTH), .AW(SW + PW)) u_ram (
    .clk    (clk),
    .we_i   (we),
    .waddr_i({ws, wr_ptr_q[ws]}),
    .wdata_i({wr_x, wr_y, wr_z}),
    .re_i   (pop),
    .raddr_i({rs, rd_ptr_q[rs]}),
    .rdata_o(rdata)
  );
  // RAM read data is unreset; gating by rd_valid gives zero outputs out of reset and while idle,
  // and the RAM register only changes on a new pop, so data holds steady throughout OUT.
  assign rd_valid = state_q == ST_OUT;
  assign rd_req_ready = state_q == ST_IDLE;
  assign rd_sys = rd_sys_q;
  assign {rd_x, rd_y, rd_z} = rd_valid ? rdata : '0;
  assign ovf = ovf_q;
  assign err_pulse = err_q;
endmodule

// File: tb/tb_chaos_sample_reader.sv
// tb_chaos_sample_reader: directed and random checks of chaos_sample_reader against a queue model
module tb_chaos_sample_reader;
  import chaos_pkg::*;
  localparam int NS = 6;
  localparam int D = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic wr_valid = 1'b0;
  logic [7:0] wr_sys = '0;
  logic [63:0] wr_x = '0, wr_y = '0, wr_z = '0;
  logic rd_req_valid = 1'b0;
  logic [7:0] rd_req_sys = '0;
  logic rd_ready = 1'b0;
  logic rd_req_ready, rd_valid, ovf, err_pulse;
  logic [7:0] rd_sys;
  logic [63:0] rd_x, rd_y, rd_z;
  int n_run = 0;
  int n_fail = 0;
  sample_t q [NS][$];
  bit m_out = 0, m_ovf = 0, m_err = 0;
  logic [7:0] m_sys = '0;
  sample_t m_data;
  always #5 clk = ~clk;
  chaos_sample_reader dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_sys(wr_sys), .wr_x(wr_x), .wr_y(wr_y), .wr_z(wr_z),
    .rd_req_valid(rd_req_valid), .rd_req_sys(rd_req_sys), .rd_req_ready(rd_req_ready),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_sys(rd_sys),
    .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z), .ovf(ovf), .err_pulse(err_pulse)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Model one clock edge from the current inputs, then compare outputs just after the edge.
  task automatic step();
    bit acc;
    sample_t s;
    acc = !m_out && rd_req_valid && int'(rd_req_sys) < NS && q[int'(rd_req_sys)].size() > 0;
    m_err = (wr_valid && int'(wr_sys) >= NS) || (!m_out && rd_req_valid && !acc);
    if (acc) begin
      m_data = q[int'(rd_req_sys)].pop_front();
      m_sys = rd_req_sys;
    end
    if (wr_valid && int'(wr_sys) < NS) begin
      s.x = wr_x; s.y = wr_y; s.z = wr_z;
      if (q[int'(wr_sys)].size() < D) q[int'(wr_sys)].push_back(s);
      else begin
        m_ovf = 1;
`ifdef CHAOS_RD_OVERWRITE_EN
        void'(q[int'(wr_sys)].pop_front());
        q[int'(wr_sys)].push_back(s);
`endif
      end
    end
    m_out = acc ? 1'b1 : (m_out && rd_ready) ? 1'b0 : m_out;
    @(posedge clk);
    #1;
    chk("rd_valid", rd_valid, m_out);
    chk("rd_req_ready", rd_req_ready, !m_out);
    chk("err_pulse", err_pulse, m_err);
    chk("ovf", ovf, m_ovf);
    if (m_out) begin
      chk("rd_sys", rd_sys, m_sys);
      chk("rd_x", rd_x, m_data.x);
      chk("rd_y", rd_y, m_data.y);
      chk("rd_z", rd_z, m_data.z);
    end
  endtask
  task automatic drive(input logic wv, input logic [7:0] ws, input logic [63:0] x,
                       input logic rv, input logic [7:0] rs, input logic rr);
    wr_valid = wv; wr_sys = ws; wr_x = x; wr_y = {$urandom, $urandom}; wr_z = ~x ^ 64'(ws);
    rd_req_valid = rv; rd_req_sys = rs; rd_ready = rr;
    step();
  endtask
  task automatic do_reset();
    wr_valid = 0; rd_req_valid = 0; rd_ready = 0; wr_sys = '0; rd_req_sys = '0;
    rst_n = 0;
    #2;
    foreach (q[i]) q[i].delete();
    m_out = 0; m_ovf = 0; m_err = 0;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err_pulse, 0);
    chk("rst_rd_sys", rd_sys, 0);
    chk("rst_rd_x", rd_x, 0);
    @(posedge clk);
    #2;
    rst_n = 1;
    #1;
    chk("rst_ready", rd_req_ready, 1);
  endtask
  initial begin
    #1;
    do_reset();
    // single write then read back
    drive(1, 2, 64'd1, 0, 0, 0);
    wr_y = 64'd2;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 2, 0);
    chk("r023_sys", rd_sys, 2);
    chk("r023_x", rd_x, 1);
    drive(0, 0, 0, 0, 0, 1);
    // empty and out-of-range requests
    drive(0, 0, 0, 1, 4, 0);
    chk("r024_err", err_pulse, 1);
    chk("r024_valid", rd_valid, 0);
    drive(0, 0, 0, 1, 7, 0);
    chk("bad_sys_err", err_pulse, 1);
    drive(1, 6, 64'd5, 0, 0, 0);
    chk("bad_wr_err", err_pulse, 1);
    // stall in OUT; a request arriving meanwhile is neither accepted nor an error
    drive(1, 5, 64'd55, 0, 0, 0);
    drive(0, 0, 0, 1, 5, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 5, 0);
      chk("r027_x", rd_x, 55);
      chk("r027_ready", rd_req_ready, 0);
    end
    drive(0, 0, 0, 0, 0, 1);
    chk("r027_idle", rd_req_ready, 1);
    // overflow of system 0
    for (int i = 0; i <= D; i++) drive(1, 0, 64'(i), 0, 0, 0);
    chk("r025_ovf", ovf, 1);
    for (int i = 0; i < D; i++) begin
      drive(0, 0, 0, 1, 0, 0);
`ifdef CHAOS_RD_OVERWRITE_EN
      chk("r025_x", rd_x, 64'(i + 1));
`else
      chk("r025_x", rd_x, 64'(i));
`endif
      drive(0, 0, 0, 0, 0, 1);
    end
    // full buffer with simultaneous write and pop
    do_reset();
    for (int i = 0; i < D; i++) drive(1, 1, 64'(100 + i), 0, 0, 0);
    drive(1, 1, 64'd99, 1, 1, 0);
    chk("r026_x", rd_x, 100);
    chk("r026_ovf", ovf, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 1, 64'd200, 0, 0, 0);
    chk("r026_still_full", ovf, 1);
    // reset while a response is pending
    drive(1, 3, 64'd7, 0, 0, 0);
    drive(1, 3, 64'd8, 0, 0, 0);
    drive(0, 0, 0, 1, 3, 0);
    chk("r028_out", rd_valid, 1);
    do_reset();
    drive(0, 0, 0, 1, 3, 0);
    chk("r028_err", err_pulse, 1);
    // random traffic, biased toward systems 0/1 so buffers fill up
    for (int i = 0; i < 800; i++)
      drive(1'($urandom_range(0, 3) != 0),
            8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : $urandom_range(0, 1)),
            {$urandom, $urandom}, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/chaos_sample_reader.md
CHAOS_SAMPLE_READER -- requirements
Module: chaos_sample_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of each state sample x/y/z.
REQ-002 SHALL have parameter SYS_NUM, default 6, number of chaotic systems buffered.
REQ-003 SHALL have parameter DEPTH, default 16 (power of 2), samples buffered per system.
REQ-004 SHALL have ports:
  clk  in  1  sole clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  wr_valid  in  1  sample present this cycle, no backpressure.
  wr_sys  in  8  system index of sample.
  wr_x / wr_y / wr_z  in  DATA_WIDTH each  signed samples.
  rd_req_valid  in  1  read request.
  rd_req_sys  in  8  system index requested.
  rd_req_ready  out  1  request accepted when valid&ready.
  rd_valid  out  1  response valid.
  rd_ready  in  1  consumer accepts response.
  rd_sys  out  8  system index of response.
  rd_x / rd_y / rd_z  out  DATA_WIDTH each  response samples.
  ovf  out  1  sticky write-overflow flag.
  err_pulse  out  1  one-cycle error pulse.

Function
REQ-005 SHALL hold one circular buffer per system in a single memory addressed {sys, ptr}, with per-system wr_ptr, rd_ptr and count (0..DEPTH).
REQ-006 SHALL write {x,y,z} at wr_ptr[wr_sys] and increment wr_ptr/count when wr_valid and wr_sys<SYS_NUM and the buffer is not full.
REQ-007 SHALL ignore wr_valid with wr_sys>=SYS_NUM and pulse err_pulse.
REQ-008 SHALL implement FSM IDLE/OUT; rd_req_ready=1 only in IDLE.
REQ-009 SHALL, on request accepted in IDLE with count>0, read memory at rd_ptr (read-first), increment rd_ptr, decrement count, and enter OUT with rd_valid=1 the next cycle (latency 1).
REQ-010 SHALL, on request to an empty system or index>=SYS_NUM, stay IDLE, pulse err_pulse, change no pointers.
REQ-011 SHALL hold rd_valid, rd_sys, rd_x/y/z stable in OUT until rd_valid&rd_ready, then return to IDLE (one response per two cycles maximum).
REQ-012 SHALL treat a write and an accepted read on the same system in one cycle as net count unchanged; the write to a full buffer is accepted because the pop frees the slot, and the read returns the old data.
REQ-013 SHALL evaluate emptiness at acceptance using pre-cycle count; a same-cycle write is not readable that cycle.
REQ-014 SHALL set ovf when a write targets a full buffer without a same-cycle pop; ovf clears only on reset.
REQ-015 SHALL wrap pointers modulo DEPTH with no extra handling.

Reset
REQ-016 SHALL on rst_n low asynchronously force FSM=IDLE, all pointers/counts=0, rd_valid=0, rd_sys=0, rd_x/y/z=0, ovf=0, err_pulse=0; rd_req_ready=1 after release.
REQ-017 SHALL not reset memory contents; reset mid-OUT discards the pending response.

Configuration
REQ-018 SHALL support macro CHAOS_RD_OVERWRITE_EN.
REQ-019 With CHAOS_RD_OVERWRITE_EN defined, a write to a full buffer SHALL overwrite the oldest sample, advance rd_ptr and wr_ptr, keep count=DEPTH, and set ovf.
REQ-020 Without it, such a write SHALL be dropped and ovf set.

Structure
REQ-021 Package chaos_pkg SHALL hold DATA_WIDTH/SYS_NUM defaults, FSM state enum, and sample struct {x,y,z}.
REQ-022 Sub-module chaos_sample_ram (simple dual-port, sync read-first, 3*DATA_WIDTH wide) SHALL hold the memory.

Verification
REQ-023 Write sys2 x=1,y=2,z=3; request sys2 -> rd_valid next cycle, rd_sys=2, rd_x=1, rd_y=2, rd_z=3.
REQ-024 Request sys4 while empty -> err_pulse one cycle, rd_valid stays 0, rd_req_ready stays 1.
REQ-025 17 writes to sys0 (x=0..16), no reads -> ovf=1; reads return x=0..15 (macro off) or x=1..16 (macro on).
REQ-026 Sys1 full (16), simultaneous write x=99 and request -> oldest sample returned, count stays 16, ovf=0.
REQ-027 Hold rd_ready=0 for 5 cycles in OUT -> outputs stable, rd_req_ready=0; then rd_ready=1 -> IDLE next cycle.
REQ-028 Assert rst_n=0 during OUT -> rd_valid=0 immediately; after release, any request returns err_pulse (empty).
